// File: rtl/i2s_rx_master.sv
// rtl/i2s_rx_master.sv - I2S bus-master receiver: SCK/WS generation, stereo frame capture, valid/ready output
module i2s_rx_master #(
    parameter int SAMPLE_W = 32,
    parameter int SLOT_W   = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sd_i,
    output logic                  sck_o,
    output logic                  ws_o,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [2*SAMPLE_W-1:0] out_data,
    output logic [15:0]           ovf_cnt
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BC_W  = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * SLOT_W - 1);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]  SLOT     = BC_W'(SLOT_W);
    localparam logic [BC_W-1:0]  SAMP     = BC_W'(SAMPLE_W);

    logic [DIV_W-1:0]    div_cnt;
    logic [BC_W-1:0]     bc;
    logic [SAMPLE_W-1:0] left_sr;
    logic [SAMPLE_W-1:0] right_sr;
    logic                armed;

    logic                tick;
    logic                rise;
    logic                fall;
    logic [BC_W-1:0]     bc_next;
    logic [BC_W-1:0]     rel;
    logic                cap_left;
    logic                cap_right;
    logic                complete;
    logic [SAMPLE_W-1:0] right_next;

    // SCK edge events and slot decode; rel is bc measured from the start of the right slot
    always_comb begin
        tick       = en && (div_cnt == DIV_LAST);
        rise       = tick && !sck_o;
        fall       = tick && sck_o;
        bc_next    = (bc == BC_LAST) ? '0 : bc + BC_ONE;
        rel        = (bc >= SLOT) ? bc - SLOT : bc + SLOT;
        cap_left   = rise && (bc != '0) && (bc <= SAMP);
        cap_right  = rise && (rel != '0) && (rel <= SAMP);
        complete   = rise && armed && (rel == SAMP);
        right_next = (right_sr << 1) | SAMPLE_W'(sd_i);
    end

    // Clock divider, bit clock, bit counter and word select; all held at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
            ws_o    <= 1'b0;
            bc      <= '0;
        end else if (!en) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
            ws_o    <= 1'b0;
            bc      <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
            if (tick) begin
                sck_o <= !sck_o;
            end
            if (fall) begin
                bc   <= bc_next;
                ws_o <= (bc_next >= SLOT);
            end
        end
    end

    // Sample shift registers; armed marks that a full left word has started since enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_sr  <= '0;
            right_sr <= '0;
            armed    <= 1'b0;
        end else if (!en) begin
            left_sr  <= '0;
            right_sr <= '0;
            armed    <= 1'b0;
        end else begin
            if (cap_left) begin
                left_sr <= (left_sr << 1) | SAMPLE_W'(sd_i);
                if (bc == BC_ONE) begin
                    armed <= 1'b1;
                end
            end
            if (cap_right) begin
                right_sr <= right_next;
            end
        end
    end

    // Output holding register: load on completion when free, otherwise drop and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            ovf_cnt  <= '0;
        end else if (complete && (!out_vld || out_rdy)) begin
            out_vld  <= 1'b1;
            out_data <= {left_sr, right_next};
        end else begin
            if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
            if (complete && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx_master.sv
// tb/tb_i2s_rx_master.sv - directed bench for i2s_rx_master with codec model and output scoreboard
module tb_i2s_rx_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, sd_a, rdy_a, sck_a, ws_a, vld_a;
    logic [47:0] data_a;
    logic [15:0] ovf_a;
    logic        en_b, sd_b, rdy_b, sck_b, ws_b, vld_b;
    logic [63:0] data_b;
    logic [15:0] ovf_b;

    i2s_rx_master #(.SAMPLE_W(24), .SLOT_W(32), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .sd_i(sd_a), .sck_o(sck_a), .ws_o(ws_a),
        .out_vld(vld_a), .out_rdy(rdy_a), .out_data(data_a), .ovf_cnt(ovf_a)
    );

    i2s_rx_master #(.SAMPLE_W(32), .SLOT_W(32), .CLK_DIV(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .sd_i(sd_b), .sck_o(sck_b), .ws_o(ws_b),
        .out_vld(vld_b), .out_rdy(rdy_b), .out_data(data_b), .ovf_cnt(ovf_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Codec word tables, indexed by frame number modulo 8
    logic [31:0] lw_a [8];
    logic [31:0] rw_a [8];
    logic [31:0] lw_b [8];
    logic [31:0] rw_b [8];

    function automatic logic [63:0] exp_a(input int f);
        return {16'h0, lw_a[f % 8][23:0], rw_a[f % 8][23:0]};
    endfunction

    function automatic logic [63:0] exp_b(input int f);
        return {lw_b[f % 8], rw_b[f % 8]};
    endfunction

    // Bit the codec places on the line for a given bit slot; padding drives 1
    function automatic logic codec_bit(input int bc, input int sw, input int sl,
                                       input logic [31:0] l, input logic [31:0] r_cur,
                                       input logic [31:0] r_prev);
        int rel;
        if (bc >= 1 && bc <= sw) return l[sw - bc];
        rel = (bc >= sl) ? bc - sl : bc + sl;
        if (rel >= 1 && rel <= sw) return (bc < sl) ? r_prev[sw - rel] : r_cur[sw - rel];
        return 1'b1;
    endfunction

    int   bcm_a, frm_a, bcm_b, frm_b;
    logic psck_a, psck_b;

    // Codec models: count SCK falls independently and drive the next bit after each fall
    always @(negedge clk) begin
        if (!rst_n) begin
            bcm_a = 0; frm_a = 0; psck_a = 1'b0; sd_a = 1'($urandom);
            bcm_b = 0; frm_b = 0; psck_b = 1'b0; sd_b = 1'($urandom);
        end else begin
            if (!en_a) begin
                bcm_a = 0; frm_a = 0;
            end else if (psck_a && !sck_a) begin
                bcm_a = (bcm_a + 1) % 64;
                if (bcm_a == 0) frm_a++;
            end
            psck_a = sck_a;
            sd_a = codec_bit(bcm_a, 24, 32, lw_a[frm_a % 8], rw_a[frm_a % 8], rw_a[(frm_a + 7) % 8]);
            if (!en_b) begin
                bcm_b = 0; frm_b = 0;
            end else if (psck_b && !sck_b) begin
                bcm_b = (bcm_b + 1) % 64;
                if (bcm_b == 0) frm_b++;
            end
            psck_b = sck_b;
            sd_b = codec_bit(bcm_b, 32, 32, lw_b[frm_b % 8], rw_b[frm_b % 8], rw_b[(frm_b + 7) % 8]);
        end
    end

    // Output monitor: record accepted frames and word-select rising times
    logic [63:0] q_a [$];
    logic [63:0] q_b [$];
    int          ws_rise_a [$];
    int          cyc = 0;
    logic        pws_a = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        #1;
        if (rst_n && vld_a && rdy_a) q_a.push_back(64'(data_a));
        if (rst_n && vld_b && rdy_b) q_b.push_back(data_b);
        if (ws_a && !pws_a) ws_rise_a.push_back(cyc);
        pws_a = ws_a;
    end

    task automatic wait_vld(input int which, input string tag);
        int n = 0;
        @(negedge clk);
        while (((which == 0) ? vld_a : vld_b) == 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 64'((which == 0) ? vld_a : vld_b), 64'd1);
    endtask

    task automatic wait_pop(input int which, input string tag, output logic [63:0] d);
        int n = 0;
        while (((which == 0) ? q_a.size() : q_b.size()) == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 64'(((which == 0) ? q_a.size() : q_b.size()) != 0), 64'd1);
        d = 64'h0;
        if (which == 0 && q_a.size() != 0) d = q_a.pop_front();
        if (which == 1 && q_b.size() != 0) d = q_b.pop_front();
    endtask

    logic [63:0] d;
    logic [63:0] held;
    int          f;
    int          n;

    initial begin
        for (int i = 0; i < 8; i++) begin
            lw_a[i] = 32'h00ABC000 + 32'(i) * 32'h00011111;
            rw_a[i] = 32'h00555000 + 32'(i) * 32'h0001001F;
            lw_b[i] = 32'h13570000 + 32'(i) * 32'h01010101;
            rw_b[i] = 32'h2468ACE0 + 32'(i) * 32'h10001001;
        end
        lw_a[0] = 32'h00A5A5A5;
        rw_a[0] = 32'h00123456;
        lw_b[0] = 32'h80000001;
        rw_b[0] = 32'hFFFF0000;

        // Reset held with enable high and data toggling
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_sck_a", 64'(sck_a), 64'd0);
        chk("rst_ws_a", 64'(ws_a), 64'd0);
        chk("rst_vld_a", 64'(vld_a), 64'd0);
        chk("rst_ovf_a", 64'(ovf_a), 64'd0);
        chk("rst_data_a", 64'(data_a), 64'd0);
        chk("rst_sck_b", 64'(sck_b), 64'd0);
        chk("rst_vld_b", 64'(vld_b), 64'd0);
        en_a = 1'b0; en_b = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // First rise CLK_DIV cycles after enable
        en_a = 1'b1;
        @(negedge clk);
        chk("sck_before_first_rise", 64'(sck_a), 64'd0);
        @(negedge clk);
        chk("sck_first_rise", 64'(sck_a), 64'd1);

        // Basic frame with out_rdy high
        wait_vld(0, "basic_vld");
        chk("basic_vld_bc", 64'(bcm_a), 64'd56);
        chk("basic_vld_sck", 64'(sck_a), 64'd1);
        wait_pop(0, "basic", d);
        chk("basic_data", d, 64'h0000A5A5A5123456);
        chk("basic_vld_one_cycle", 64'(vld_a), 64'd0);
        n = 0;
        while (ws_rise_a.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ws_rises_seen", 64'(ws_rise_a.size() >= 3), 64'd1);
        if (ws_rise_a.size() >= 3) chk("ws_period", 64'(ws_rise_a[2] - ws_rise_a[1]), 64'd256);

        // Backpressure across three frames: first held, two dropped
        while (q_a.size() != 0) void'(q_a.pop_front());
        @(negedge clk);
        rdy_a = 1'b0;
        wait_vld(0, "bp_vld");
        f = frm_a;
        held = exp_a(f);
        repeat (522) @(negedge clk);
        chk("bp_ovf", 64'(ovf_a), 64'd2);
        chk("bp_vld_held", 64'(vld_a), 64'd1);
        chk("bp_data_held", 64'(data_a), held);
        // Accept in the very cycle the next frame completes: reload, no drop
        repeat (245) @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        chk("simul_vld", 64'(vld_a), 64'd1);
        chk("simul_data", 64'(data_a), exp_a(f + 3));
        chk("simul_ovf", 64'(ovf_a), 64'd2);
        wait_pop(0, "bp_first", d);
        chk("bp_first_intact", d, held);
        @(negedge clk);
        chk("simul_vld_clear", 64'(vld_a), 64'd0);
        wait_pop(0, "simul", d);
        chk("simul_accepted", d, exp_a(f + 3));

        // Enable drop mid-frame with a held frame pending
        rdy_a = 1'b0;
        wait_vld(0, "en_vld");
        held = exp_a(frm_a);
        n = 0;
        while (!(bcm_a == 20 && sck_a) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("en_bc20_reached", 64'(bcm_a), 64'd20);
        en_a = 1'b0;
        @(negedge clk);
        chk("en_sck_cleared", 64'(sck_a), 64'd0);
        chk("en_ws_cleared", 64'(ws_a), 64'd0);
        chk("en_vld_held", 64'(vld_a), 64'd1);
        repeat (300) @(negedge clk);
        chk("en_data_held", 64'(data_a), held);
        chk("en_ovf_kept", 64'(ovf_a), 64'd2);
        rdy_a = 1'b1;
        @(negedge clk);
        chk("en_vld_after_accept", 64'(vld_a), 64'd0);
        wait_pop(0, "en_held", d);
        chk("en_held_frame", d, held);
        en_a = 1'b1;
        wait_vld(0, "reen_vld");
        chk("reen_vld_bc", 64'(bcm_a), 64'd56);
        wait_pop(0, "reen", d);
        chk("reen_data", d, exp_a(0));
        chk("reen_ovf", 64'(ovf_a), 64'd2);
        en_a = 1'b0;

        // Full-slot configuration: completion lands on bc 0 of the next frame
        en_b = 1'b1;
        wait_vld(1, "full_vld");
        chk("full_vld_bc", 64'(bcm_b), 64'd0);
        chk("full_vld_frame", 64'(frm_b), 64'd1);
        wait_pop(1, "full", d);
        chk("full_data", d, 64'h80000001FFFF0000);
        chk("full_vld_one_cycle", 64'(vld_b), 64'd0);

        // Saturation: preload the counter near the top, then keep dropping
        rdy_b = 1'b0;
        wait_vld(1, "sat_vld");
        held = exp_b(frm_b - 1);
        force dut_b.ovf_cnt = 16'hFFFD;
        @(negedge clk);
        release dut_b.ovf_cnt;
        repeat (256) @(negedge clk);
        chk("sat_step", 64'(ovf_b), 64'hFFFE);
        repeat (768) @(negedge clk);
        chk("sat_ovf", 64'(ovf_b), 64'hFFFF);
        chk("sat_data_held", data_b, held);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
